// File: rtl/amadeus_pkg.sv
// Shared definitions for the accelerator memory-side blocks.
//   MEM_ADDR_SIZE / MEM_BANDWIDTH : memory interface address bits / bytes per word
//   ERR_*                         : bit positions inside err_status
//   wsrc_e                        : which requester owns the single array write port
package amadeus_pkg;

  localparam int unsigned MEM_ADDR_SIZE = 16;
  localparam int unsigned MEM_BANDWIDTH = 4;

  localparam int unsigned ERR_OOR   = 0;
  localparam int unsigned ERR_RW    = 1;
  localparam int unsigned ERR_LDCOL = 2;
  localparam int unsigned ERR_W     = 3;

  typedef logic [ERR_W-1:0] err_vec_t;

  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_HOST = 2'd1,
    WSRC_MEM  = 2'd2
  } wsrc_e;

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid+data delay line that follows the read sample stage of mem_responder.
//   clk, rst : clock, synchronous active-high reset (clears valids and data)
//   i_vld    : read sample valid entering the line
//   i_data   : read sample data entering the line
//   o_vld    : last stage valid (read response strobe)
//   o_data   : last stage data, holds its value while no response is delivered
//   o_busy   : OR of all stage valid bits
module mem_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic [STAGES-1:0] r_vld;
  logic [DATA_W-1:0] r_data [STAGES];

  // Data registers only load behind a valid bit, so the final stage keeps
  // the last delivered word while the strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[STAGES-1];
  assign o_data = r_data[STAGES-1];
  assign o_busy = |r_vld;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder facing the accelerator's memory master port.
//   clk, rst             : clock, synchronous active-high reset
//   mem_addr/read/write  : accelerator request (no backpressure)
//   mem_write_data       : accelerator write data
//   mem_read_data        : read response data (holds while mem_valid=0)
//   mem_valid            : one-cycle strobe per accepted read, READ_LATENCY after accept
//   ld_en/ld_addr/ld_data: host preload write port, wins over mem_write
//   err_clr              : clears sticky err_status (a same-cycle new error wins)
//   err_status           : [ERR_OOR] out of range, [ERR_RW] read+write, [ERR_LDCOL] preload collision
//   rd_cnt / wr_cnt      : saturating accepted read / write counters
//   busy                 : at least one read in flight
// READ_LATENCY legal range is 1..4.
module mem_responder
  import amadeus_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_SIZE,
  parameter int unsigned DATA_W       = MEM_BANDWIDTH * 8,
  parameter int unsigned DEPTH        = 8192,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              err_clr,
  output logic [2:0]        err_status,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic              busy
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_addr_oor;
  logic              w_ld_oor;
  logic              w_rd_acc;
  logic [IDX_W-1:0]  w_ridx;
  wsrc_e             w_wsrc;
  logic [IDX_W-1:0]  w_widx;
  logic [DATA_W-1:0] w_wdata;
  err_vec_t          w_err_set;

  err_vec_t          r_err;
  logic [31:0]       r_rd_cnt;
  logic [31:0]       r_wr_cnt;
  logic              r_s1_vld;
  logic [DATA_W-1:0] r_s1_data;
  logic              w_pipe_busy;

  // Request decode and single write-port arbitration.
  always_comb begin
    w_addr_oor = ({1'b0, mem_addr} >= LP_DEPTH);
    w_ld_oor   = ({1'b0, ld_addr} >= LP_DEPTH);
    w_rd_acc   = mem_read && !mem_write;
    w_ridx     = mem_addr[IDX_W-1:0];

    w_wsrc  = WSRC_NONE;
    w_widx  = '0;
    w_wdata = '0;
    // A preload owns the port even when it is out of range, so the
    // colliding mem_write is still discarded.
    if (ld_en) begin
      if (!w_ld_oor) begin
        w_wsrc  = WSRC_HOST;
        w_widx  = ld_addr[IDX_W-1:0];
        w_wdata = ld_data;
      end
    end else if (mem_write && !w_addr_oor) begin
      w_wsrc  = WSRC_MEM;
      w_widx  = mem_addr[IDX_W-1:0];
      w_wdata = mem_write_data;
    end

    w_err_set            = '0;
    w_err_set[ERR_OOR]   = ((mem_read || mem_write) && w_addr_oor) || (ld_en && w_ld_oor);
    w_err_set[ERR_RW]    = mem_read && mem_write;
    w_err_set[ERR_LDCOL] = ld_en && mem_write;
  end

  // Array contents are never reset; writes presented during reset are ignored.
  always_ff @(posedge clk) begin
    if (!rst && (w_wsrc != WSRC_NONE)) begin
      r_mem[w_widx] <= w_wdata;
    end
  end

  // Stage 1: sample the array at the accept edge. Nonblocking array update
  // means a same-edge preload is seen by later reads only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_addr_oor ? '0 : r_mem[w_ridx];
      end
    end
  end

  // Sticky errors: clear first, then OR in this cycle's events.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr ? '0 : r_err) | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_acc && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (mem_write && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  generate
    if (READ_LATENCY <= 1) begin : g_direct
      assign mem_valid     = r_s1_vld;
      assign mem_read_data = r_s1_data;
      assign w_pipe_busy   = 1'b0;
    end else begin : g_pipe
      mem_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LATENCY - 1)
      ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_s1_vld),
        .i_data (r_s1_data),
        .o_vld  (mem_valid),
        .o_data (mem_read_data),
        .o_busy (w_pipe_busy)
      );
    end
  endgenerate

  assign busy       = r_s1_vld | w_pipe_busy;
  assign err_status = r_err;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import amadeus_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          mem_valid;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          err_clr;
  logic [2:0]    err_status;
  logic [31:0]   rd_cnt;
  logic [31:0]   wr_cnt;
  logic          busy;

  mem_responder #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_valid      (mem_valid),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .err_clr        (err_clr),
    .err_status     (err_status),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] mdl [int unsigned];
  int unsigned   cyc    = 0;
  int unsigned   total  = 0;
  int unsigned   bad    = 0;
  int unsigned   exp_rd = 0;
  int unsigned   exp_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding read,
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_valid observed data=%h expected no strobe", mem_read_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rd_data", mem_read_data, mon_e.data);
        chk("rd_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      total++;
      assert (mem_valid === 1'b1) else begin
        bad++;
        $error("FAIL missing_valid observed=%b expected strobe data=%h at cycle %0d",
               mem_valid, sb[0].data, sb[0].due);
      end
      void'(sb.pop_front());
    end
  end

  // One clock: drive at the negedge, update the bench model, wait for the
  // next negedge so outputs are sampled half a cycle after the edge.
  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic ld, input logic [AW-1:0] la,
                      input logic [DW-1:0] lv, input logic clr, input logic r);
    exp_t        n;
    int unsigned ai;
    int unsigned li;
    ai = int'(a);
    li = int'(la);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_write_data = wd;
    ld_en = ld; ld_addr = la; ld_data = lv; err_clr = clr; rst = r;
    if (r) begin
      sb.delete();
      exp_rd = 0;
      exp_wr = 0;
    end else begin
      if (rd && !wr) begin
        exp_rd++;
        n.data = (ai >= DEPTH) ? '0 : mdl[ai];
        n.due  = cyc + LAT;
        sb.push_back(n);
      end
      if (wr) exp_wr++;
      if (ld) begin
        if (li < DEPTH) mdl[li] = lv;
      end else if (wr && ai < DEPTH) begin
        mdl[ai] = wd;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask
  task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b0, '0, '0, 1'b1, a, d, 1'b0, 1'b0);
  endtask
  task automatic clr();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask
  task automatic rst_cyc();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d pending expected=0", sb.size());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_data"}, mem_read_data, 32'd0);
    chk({tag, "_err"}, 32'(err_status), 32'd0);
    chk({tag, "_rdcnt"}, rd_cnt, 32'd0);
    chk({tag, "_wrcnt"}, wr_cnt, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; err_clr = 1'b0;
    rst_cyc();
    rst_cyc();
    chk_zero("reset");

    // Preload then read with fixed latency.
    ld(16'h0003, 32'h0000_00A5);
    idle();
    rd(16'h0003);
    chk("t1_busy", 32'(busy), 32'd1);
    drain();
    chk("t1_rd_cnt", rd_cnt, 32'd1);
    chk("t1_hold_data", mem_read_data, 32'h0000_00A5);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Write->read returns new data; read->write returns old data.
    wr(16'h19BA, 32'h0000_1234);
    rd(16'h19BA);
    drain();
    rd(16'h19BA);
    wr(16'h19BA, 32'h0000_5678);
    drain();
    rd(16'h19BA);
    drain();
    chk("t2_wr_cnt", wr_cnt, 32'd2);
    chk("t2_rd_cnt", rd_cnt, 32'(exp_rd));

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) ld(AW'(16'h1A12 + i), 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      rd(AW'(16'h1A12 + i));
      chk("t3_busy", 32'(busy), 32'd1);
    end
    idle();
    chk("t3_busy_last", 32'(busy), 32'd1);
    idle();
    chk("t3_busy_done", 32'(busy), 32'd0);
    drain();

    // Read and write together: write wins, read dropped.
    rst_cyc();
    step(1'b1, 1'b1, 16'h0010, 32'h0000_0077, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("t4_err", 32'(err_status), 32'b010);
    idle();
    idle();
    chk("t4_wr_cnt", wr_cnt, 32'd1);
    chk("t4_rd_cnt", rd_cnt, 32'd0);
    rd(16'h0010);
    drain();
    clr();
    chk("t4_clr", 32'(err_status), 32'b000);

    // Out-of-range read, preload collision, preload out of range.
    rd(16'h2000);
    chk("t5_oor_err", 32'(err_status), 32'b001);
    drain();
    clr();
    ld(16'h0021, 32'h0000_1111);
    step(1'b0, 1'b1, 16'h0021, 32'h0000_DEAD, 1'b1, 16'h0020, 32'h0000_BEEF, 1'b0, 1'b0);
    chk("t5_ldcol_err", 32'(err_status), 32'b100);
    rd(16'h0020);
    rd(16'h0021);
    drain();
    clr();
    chk("t5_clr", 32'(err_status), 32'b000);
    ld(16'h2000, 32'h0000_0009);
    chk("t5_ld_oor_err", 32'(err_status), 32'b001);
    step(1'b1, 1'b1, 16'h0030, 32'h0000_0005, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_clr_vs_new", 32'(err_status), 32'b010);
    step(1'b1, 1'b0, 16'h0021, '0, 1'b1, 16'h0021, 32'h0000_2222, 1'b0, 1'b0);
    drain();
    rd(16'h0021);
    drain();
    chk("t5_wr_cnt", wr_cnt, 32'(exp_wr));

    // Reset with reads in flight: nothing delivered, array survives.
    rd(16'h1A12);
    step(1'b1, 1'b0, 16'h1A13, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle();
    chk_zero("t6_reset");
    idle();
    idle();
    rd(16'h0003);
    drain();
    chk("t6_rd_cnt", rd_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable single-port memory responder that serves the accelerator's external memory interface (mem_addr / mem_read / mem_write / mem_write_data) and returns read data plus a valid strobe after a fixed latency.
- Replaces the behavioural memory model on FPGA/emulation builds, and sits directly opposite amadeus_top's memory master port.
- Adds a host preload port for ifmap, weight and compressor images, plus sticky error flags and access counters for bring-up.

Parameters:
- ADDR_W, `MEM_ADDR_SIZE (16): address width, word-addressed.
- DATA_W, `MEM_BANDWIDTH*8: data word width.
- DEPTH, 8192: number of words implemented; addresses >= DEPTH are out of range.
- READ_LATENCY, 2: cycles from read accept to mem_valid; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  ADDR_W  request address from accelerator.
- mem_read  in  1  read request, accepted every cycle it is high.
- mem_write  in  1  write request, accepted every cycle it is high.
- mem_write_data  in  DATA_W  write data.
- mem_read_data  out  DATA_W  read response data.
- mem_valid  out  1  read response strobe, one cycle per accepted read.
- ld_en  in  1  host preload write enable.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.
- err_clr  in  1  clears err_status.
- err_status  out  3  sticky flags: [0] out-of-range, [1] read+write in the same cycle, [2] preload collided with a write.
- rd_cnt  out  32  accepted reads, saturating.
- wr_cnt  out  32  accepted writes, saturating.
- busy  out  1  at least one read is in flight.

Behaviour:
- Reset, synchronous on posedge while rst=1:
  - mem_valid=0, mem_read_data=0, err_status=0, rd_cnt=0, wr_cnt=0, busy=0.
  - All pipeline valid bits are cleared; in-flight reads are dropped with no mem_valid.
  - Array contents are not reset. Requests presented during reset are ignored.
- No backpressure: a request is accepted every cycle mem_read or mem_write is high.
- Write: the array is updated at the posedge where mem_write=1. wr_cnt increments.
- Read, accepted at edge N:
  - The array is sampled at edge N into stage 1.
  - mem_valid=1 and mem_read_data are presented for exactly one cycle starting READ_LATENCY-1 cycles after edge N (registered output). READ_LATENCY=1 means valid in the cycle right after acceptance.
  - Back-to-back reads produce back-to-back mem_valid in request order.
- Read/write ordering:
  - A write at edge N followed by a read of the same address at N+1 returns the new data.
  - A read at edge N followed by a write at N+1 returns the old data.
- mem_read and mem_write in the same cycle: the write is performed and the read is dropped (no mem_valid). Set err[1]; rd_cnt is not incremented.
- Out-of-range address (mem_addr >= DEPTH):
  - Write is discarded.
  - Read still produces mem_valid with data 0.
  - err[0] is set; counters still increment.
- Preload: ld_en writes ld_data to ld_addr on the posedge.
  - If mem_write is also high, the preload wins, the mem_write is discarded and err[2] is set.
  - A preload with ld_addr >= DEPTH is discarded and sets err[0].
  - A preload alongside mem_read is legal: the read samples before the update, so it returns old data.
- mem_read_data holds its last value while mem_valid=0.
- err_status bits are sticky.
  - err_clr clears them at the posedge.
  - If err_clr coincides with a new error event, the new error wins (the bit stays 1).
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- busy = OR of pipeline valid bits, combinational from registers.

Decomposition:
- Shared package amadeus_pkg, referenced by this block:
  - `MEM_ADDR_SIZE, `MEM_BANDWIDTH.
  - Error-bit index constants ERR_OOR=0, ERR_RW=1, ERR_LDCOL=2.
- One sub-module, mem_rd_pipe: a parameterized valid+data delay line (depth READ_LATENCY-1) that produces mem_valid and mem_read_data.
- Array, write arbitration, errors and counters stay in mem_responder.

Test Plan:
- Preload 0x0003=0xA5, then read 0x0003 at cycle 10 with READ_LATENCY=2 -> mem_valid=1 at cycle 11 with data 0xA5, low otherwise; rd_cnt=1.
- Write 0x19BA=0x1234 at cycle N, read 0x19BA at N+1 -> returns 0x1234. Read at N then write 0x5678 at N+1 -> returns 0x1234.
- Four back-to-back reads of 0x1A12..0x1A15 -> four consecutive mem_valid pulses, data in address order, busy high throughout then low.
- mem_read=mem_write=1 at 0x0010 with data 0x77 -> no mem_valid, array[0x10]=0x77, err_status=3'b010, wr_cnt=1, rd_cnt=0. err_clr -> 3'b000.
- Read at address 0x2000 (DEPTH=8192) -> mem_valid with data 0, err[0]=1. ld_en and mem_write in the same cycle -> ld_data stored, err[2]=1.
- Issue two reads, assert rst on the next edge -> no mem_valid ever, all outputs 0, counters 0; earlier preloaded data is still readable after reset.
